// File: rtl/user_flash_arbiter.sv
// Two-port round-robin arbiter in front of a single-bit SPI flash: each grant runs one
// READ (opcode, 24-bit address, 4 data bytes) and returns a little-endian 32-bit word.
module user_flash_arbiter #(
    parameter int         CLK_DIV  = 2,
    parameter logic [7:0] READ_CMD = 8'h03
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req0_valid,
    input  logic [23:0] req0_addr,
    output logic        req0_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_data,
    input  logic        req1_valid,
    input  logic [23:0] req1_addr,
    output logic        req1_ready,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_data,
    output logic        spi_csb_o,
    output logic        spi_clk_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i,
    output logic        busy_o,
    output logic        grant_o
);

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        CMD,
        ADDR,
        DATA,
        CS_HOLD,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic          half_q, half_d;
    logic [5:0]    bit_q, bit_d;
    logic [31:0]   tx_q, tx_d;
    logic [31:0]   rx_q, rx_d;
    logic          grant_q, grant_d;
    logic [31:0]   rsp0_data_q, rsp0_data_d;
    logic [31:0]   rsp1_data_q, rsp1_data_d;

    logic sel;
    logic accept;
    logic last_div;
    logic in_bits;

    // Tie goes to the port that did not own the previous transfer.
    always_comb begin
        if (req0_valid && req1_valid) begin
            sel = ~grant_q;
        end else begin
            sel = req1_valid;
        end
        accept = (state_q == IDLE) && (req0_valid || req1_valid) && !wb_rst_i;
    end

    assign last_div = (div_q == DIV_LAST);
    assign in_bits  = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        half_d      = half_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        grant_d     = grant_q;
        rsp0_data_d = rsp0_data_q;
        rsp1_data_d = rsp1_data_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    grant_d = sel;
                    tx_d    = {READ_CMD, (sel ? req1_addr : req0_addr)};
                    div_d   = '0;
                    half_d  = 1'b0;
                    bit_d   = '0;
                    state_d = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (last_div) begin
                    div_d   = '0;
                    state_d = CMD;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            CMD, ADDR, DATA: begin
                // MISO is captured in the first cycle of the SCK-high half.
                if ((state_q == DATA) && half_q && (div_q == '0)) begin
                    rx_d = {rx_q[30:0], spi_miso_i};
                end
                if (!last_div) begin
                    div_d = div_q + DW'(1);
                end else begin
                    div_d  = '0;
                    half_d = ~half_q;
                    if (half_q) begin
                        tx_d = {tx_q[30:0], 1'b0};
                        if (bit_q == 6'd63) begin
                            bit_d   = '0;
                            state_d = CS_HOLD;
                        end else begin
                            bit_d = bit_q + 6'd1;
                            if (bit_q == 6'd7) begin
                                state_d = ADDR;
                            end else if (bit_q == 6'd31) begin
                                state_d = DATA;
                            end
                        end
                    end
                end
            end
            CS_HOLD: begin
                if (!last_div) begin
                    div_d = div_q + DW'(1);
                end else begin
                    div_d  = '0;
                    half_d = ~half_q;
                    if (half_q) begin
                        // First flash byte lands in the least significant byte.
                        if (grant_q) begin
                            rsp1_data_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                        end else begin
                            rsp0_data_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                        end
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            div_q       <= '0;
            half_q      <= 1'b0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            grant_q     <= 1'b1;
            rsp0_data_q <= '0;
            rsp1_data_q <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            half_q      <= half_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            grant_q     <= grant_d;
            rsp0_data_q <= rsp0_data_d;
            rsp1_data_q <= rsp1_data_d;
        end
    end

    // Pad outputs decode straight from state so reset forces CSB high / SCK low at once.
    assign spi_csb_o  = !((state_q == CS_SETUP) || in_bits);
    assign spi_clk_o  = in_bits && half_q;
    assign spi_mosi_o = ((state_q == CS_SETUP) || (state_q == CMD) || (state_q == ADDR)) && tx_q[31];

    assign req0_ready = accept && !sel;
    assign req1_ready = accept && sel;
    assign rsp0_valid = (state_q == RESP) && !grant_q;
    assign rsp1_valid = (state_q == RESP) && grant_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;
    assign busy_o     = (state_q != IDLE);
    assign grant_o    = grant_q;

endmodule

// File: tb/tb_user_flash_arbiter.sv
// Bench for user_flash_arbiter: instance 0 uses CLK_DIV=2, instance 1 uses CLK_DIV=1,
// each wired to a small SPI flash model; responses and SPI frames checked from queues.
module tb_user_flash_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic        req_valid [2][2];
    logic [23:0] req_addr  [2][2];
    logic        req_ready [2][2];
    logic        rsp_valid [2][2];
    logic [31:0] rsp_data  [2][2];
    logic        csb [2];
    logic        sck [2];
    logic        mosi[2];
    logic        miso[2];
    logic        busy[2];
    logic        grant[2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        user_flash_arbiter #(
            .CLK_DIV  ((gi == 0) ? 2 : 1),
            .READ_CMD (8'h03)
        ) u_dut (
            .wb_clk_i   (clk),
            .wb_rst_i   (rst[gi]),
            .req0_valid (req_valid[gi][0]),
            .req0_addr  (req_addr[gi][0]),
            .req0_ready (req_ready[gi][0]),
            .rsp0_valid (rsp_valid[gi][0]),
            .rsp0_data  (rsp_data[gi][0]),
            .req1_valid (req_valid[gi][1]),
            .req1_addr  (req_addr[gi][1]),
            .req1_ready (req_ready[gi][1]),
            .rsp1_valid (rsp_valid[gi][1]),
            .rsp1_data  (rsp_data[gi][1]),
            .spi_csb_o  (csb[gi]),
            .spi_clk_o  (sck[gi]),
            .spi_mosi_o (mosi[gi]),
            .spi_miso_i (miso[gi]),
            .busy_o     (busy[gi]),
            .grant_o    (grant[gi])
        );
    end

    typedef struct {
        int          inst;
        int          port;
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    typedef struct {
        int          inst;
        logic [31:0] cap;
    } frame_t;

    rsp_t   rq[$];
    frame_t fq[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endfunction

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        case (a)
            24'h000010: return 8'h11;
            24'h000011: return 8'h22;
            24'h000012: return 8'h33;
            24'h000013: return 8'h44;
            default:    return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    // Flash model, frame checker and response monitor, all sampled on the falling clock edge.
    logic        prev_sck[2] = '{1'b0, 1'b0};
    logic        prev_csb[2] = '{1'b1, 1'b1};
    int          fcnt[2]     = '{0, 0};
    logic [31:0] fcap[2]     = '{32'd0, 32'd0};

    always @(negedge clk) begin
        int          k;
        logic [7:0]  b;
        rsp_t        r;
        frame_t      f;
        for (int i = 0; i < 2; i++) begin
            if (csb[i] && !prev_csb[i]) begin
                if (fq.size() > 0 && fq[0].inst == i) begin
                    f = fq.pop_front();
                    chk("mosi_frame", fcap[i], f.cap);
                    chk("sck_pulses", 32'(fcnt[i]), 32'd64);
                end
                fcnt[i] = 0;
                fcap[i] = '0;
            end
            if (!csb[i] && sck[i] && !prev_sck[i]) begin
                if (fcnt[i] < 32) fcap[i] = {fcap[i][30:0], mosi[i]};
                fcnt[i]++;
            end
            if (!csb[i] && !sck[i] && prev_sck[i] && fcnt[i] >= 32 && fcnt[i] < 64) begin
                k = fcnt[i] - 32;
                b = fbyte(24'(fcap[i][23:0] + 24'(k / 8)));
                miso[i] = b[7 - (k % 8)];
            end
            prev_sck[i] = sck[i];
            prev_csb[i] = csb[i];

            chk("ready_while_busy", {31'd0, busy[i] && (req_ready[i][0] || req_ready[i][1])}, 32'd0);
            for (int p = 0; p < 2; p++) begin
                if (rsp_valid[i][p]) begin
                    if (rq.size() == 0 || rq[0].inst != i) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: inst %0d port %0d data %h (cycle %0d)",
                                 i, p, rsp_data[i][p], cyc);
                    end else begin
                        r = rq.pop_front();
                        chk("rsp_port", 32'(p), 32'(r.port));
                        chk("rsp_data", rsp_data[i][p], r.data);
                        chk("rsp_cycle", 32'(cyc), 32'(r.cyc));
                        $display("rsp inst=%0d port=%0d data=%h cycle=%0d", i, p, rsp_data[i][p], cyc);
                    end
                end
            end
        end
    end

    task automatic accept_wait(input int inst, input int port, input logic [23:0] addr,
                               input logic [31:0] exp_data, input bit want_rsp, output int t);
        int n;
        int lat;
        n   = 0;
        t   = -1;
        lat = (inst == 0) ? 263 : 132;
        while (n < 3000) begin
            @(negedge clk);
            if (req_ready[inst][0] || req_ready[inst][1]) break;
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: inst %0d port %0d never accepted", inst, port);
            return;
        end
        t = cyc;
        chk("ready_port", {31'd0, req_ready[inst][port]}, 32'd1);
        chk("ready_other", {31'd0, req_ready[inst][1 - port]}, 32'd0);
        if (want_rsp) begin
            rq.push_back('{inst, port, exp_data, t + lat});
            fq.push_back('{inst, {8'h03, addr}});
        end
        $display("accept inst=%0d port=%0d addr=%h cycle=%0d", inst, port, addr, t);
        @(posedge clk);
        #1;
        chk("grant_after_accept", {31'd0, grant[inst]}, 32'(port));
        chk("busy_after_accept", {31'd0, busy[inst]}, 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((rq.size() > 0 || fq.size() > 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses and %0d frames outstanding", rq.size(), fq.size());
            rq.delete();
            fq.delete();
        end
    endtask

    task automatic single_read(input int inst, input int port, input logic [23:0] addr,
                               input logic [31:0] exp_data);
        int t;
        @(posedge clk);
        #1;
        req_addr[inst][port]  = addr;
        req_valid[inst][port] = 1'b1;
        accept_wait(inst, port, addr, exp_data, 1'b1, t);
        req_valid[inst][port] = 1'b0;
        wait_drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t;
        logic [23:0] a2 [2];
        logic [31:0] d2 [2];
        for (int i = 0; i < 2; i++) begin
            rst[i]  = 1'b1;
            miso[i] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                req_valid[i][p] = 1'b0;
                req_addr[i][p]  = '0;
            end
        end
        repeat (3) @(negedge clk);

        // Reset state, with a request already pending on port 0.
        req_valid[0][0] = 1'b1;
        #1;
        chk("rst_ready0", {31'd0, req_ready[0][0]}, 32'd0);
        chk("rst_csb", {31'd0, csb[0]}, 32'd1);
        chk("rst_sck", {31'd0, sck[0]}, 32'd0);
        chk("rst_mosi", {31'd0, mosi[0]}, 32'd0);
        chk("rst_busy", {31'd0, busy[0]}, 32'd0);
        chk("rst_grant", {31'd0, grant[0]}, 32'd1);
        chk("rst_rsp0_valid", {31'd0, rsp_valid[0][0]}, 32'd0);
        chk("rst_rsp0_data", rsp_data[0][0], 32'd0);
        chk("rst_rsp1_data", rsp_data[0][1], 32'd0);
        req_valid[0][0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Port 0 read of 0x000010; meanwhile port 1 raises and drops a request while busy.
        @(posedge clk);
        #1;
        req_addr[0][0]  = 24'h000010;
        req_valid[0][0] = 1'b1;
        accept_wait(0, 0, 24'h000010, 32'h44332211, 1'b1, t);
        req_valid[0][0] = 1'b0;
        req_addr[0][1]  = 24'h000040;
        req_valid[0][1] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        req_valid[0][1] = 1'b0;
        wait_drain();
        chk("rsp1_untouched", rsp_data[0][1], 32'd0);

        // Fresh reset, then both ports held for four transfers: grants 0,1,0,1.
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("grant_after_reset", {31'd0, grant[0]}, 32'd1);
        a2[0] = 24'h000100;
        d2[0] = 32'hA6A7A4A5;
        a2[1] = 24'hFFFFFF;
        d2[1] = 32'hA7A4A55A;
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            req_addr[0][p]  = a2[p];
            req_valid[0][p] = 1'b1;
        end
        for (int n = 0; n < 4; n++) begin
            accept_wait(0, n % 2, a2[n % 2], d2[n % 2], 1'b1, t);
        end
        req_valid[0][0] = 1'b0;
        req_valid[0][1] = 1'b0;
        wait_drain();
        chk("rsp0_held", rsp_data[0][0], 32'hA6A7A4A5);
        chk("rsp1_held", rsp_data[0][1], 32'hA7A4A55A);

        // Reset during DATA bit 10 (overall bit 42 spans T+171..T+174).
        @(posedge clk);
        #1;
        req_addr[0][1]  = 24'h000020;
        req_valid[0][1] = 1'b1;
        accept_wait(0, 1, 24'h000020, 32'd0, 1'b0, t);
        req_valid[0][1] = 1'b0;
        while (cyc < t + 172) @(negedge clk);
        chk("csb_low_before_rst", {31'd0, csb[0]}, 32'd0);
        rst[0] = 1'b1;
        #1;
        chk("rst_mid_csb", {31'd0, csb[0]}, 32'd1);
        chk("rst_mid_sck", {31'd0, sck[0]}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy[0]}, 32'd0);
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        chk("rst_mid_rsp0_data", rsp_data[0][0], 32'd0);
        chk("rst_mid_rsp1_data", rsp_data[0][1], 32'd0);
        single_read(0, 0, 24'h000011, 32'hB1443322);

        // CLK_DIV=1 instance.
        single_read(1, 1, 24'h0000F0, 32'h56575455);
        single_read(1, 0, 24'h000010, 32'h44332211);
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
